hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline sequencer for the IF/ID register, the PC and the ID/EX register of the 5-stage MIPS core.
- Generates the PC write enable, the IF/ID NotStall and Flush controls, the ID/EX bubble and the EX hold.
- Resolves load-use hazards, taken branches/jumps and multi-cycle multiply occupancy of EX.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
MUL_CYCLES, 4, EX-stage latency of a multiply in cycles; legal range 1..16.

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous active-high reset
MemRead_EX  input  1  instruction in EX is a load
Rt_EX  input  5  destination register of the EX-stage load
ReadReg1_ID  input  5  rs of the instruction in ID
ReadReg2_ID  input  5  rt of the instruction in ID
UsesRt_ID  input  1  ID instruction reads rt as a source
Jump_ID  input  1  ID instruction is j/jal/jr
BranchTaken_EX  input  1  branch in EX resolved taken
MulStart_ID  input  1  ID instruction is a multiply
PCWrite  output  1  PC register write enable
NotStall  output  1  IF/ID write enable
Flush  output  1  IF/ID synchronous clear
Bubble_EX  output  1  load zero control into ID/EX
Hold_EX  output  1  freeze ID/EX and EX operand registers
MulBusy  output  1  FSM in MUL_WAIT
StallCycles  output  16  saturating count of cycles with NotStall=0
FlushCount  output  16  saturating count of cycles with Flush=1

Behaviour:
- Clocking and reset:
  - Reset is asynchronous and active-high. All state updates occur on posedge Clk.
  - Reset clears state to RUN, Count to 0, StallCycles to 0 and FlushCount to 0.
  - While Reset=1 the outputs are PCWrite=1, NotStall=1, Flush=0, Bubble_EX=0, Hold_EX=0 and MulBusy=0.
  - Reset asserted mid-MUL_WAIT aborts the wait immediately.
- Control outputs are Mealy, combinational from state and inputs, and are valid in the same cycle with no added latency. The counters are registered.
- States: RUN and MUL_WAIT. Count is 4 bits.
- RUN, evaluated in priority order:
  1. BranchTaken_EX=1: Flush=1, Bubble_EX=1, PCWrite=1, NotStall=1. The wrong-path instructions in IF and ID are squashed.
  2. Jump_ID=1: Flush=1, Bubble_EX=0, PCWrite=1, NotStall=1. The IF-stage instruction is squashed.
  3. Load-use: MemRead_EX=1, Rt_EX!=0, and either Rt_EX==ReadReg1_ID or (UsesRt_ID=1 and Rt_EX==ReadReg2_ID). Outputs are PCWrite=0, NotStall=0, Bubble_EX=1, Flush=0. This gives exactly one stall cycle, because the bubble removes the load from EX in the next cycle.
  4. MulStart_ID=1 and MUL_CYCLES>1: outputs stay normal for this cycle (the multiply advances to EX). Next state is MUL_WAIT with Count=MUL_CYCLES-1.
  5. Otherwise: PCWrite=1, NotStall=1, Flush=0, Bubble_EX=0, Hold_EX=0.
- Flush and load-use priorities:
  - A flush (rule 1 or 2) that coincides with a load-use condition wins.
  - A flush that coincides with MulStart_ID suppresses the MUL_WAIT entry.
  - A load-use stall that coincides with MulStart_ID also suppresses the MUL_WAIT entry; the multiply re-presents in ID the next cycle.
- MUL_WAIT:
  - Outputs are PCWrite=0, NotStall=0, Hold_EX=1, Bubble_EX=0, Flush=0, MulBusy=1.
  - BranchTaken_EX, Jump_ID, MemRead_EX and MulStart_ID are ignored.
  - Count decrements each cycle. When Count==1, the next state is RUN.
  - MUL_WAIT therefore lasts exactly MUL_CYCLES-1 cycles.
- MUL_CYCLES=1: MUL_WAIT is never entered.
- StallCycles increments when NotStall=0, saturating at 16'hFFFF.
- FlushCount increments when Flush=1, saturating at 16'hFFFF.
- The NotStall=0 and Flush=1 outputs are never asserted together.

Test Plan:
- Reset pulse mid-MUL_WAIT (Count=2) -> outputs immediately PCWrite=1, NotStall=1, MulBusy=0; counters reset to 0; state RUN after release.
- MemRead_EX=1, Rt_EX=8, ReadReg1_ID=8 for one cycle, then MemRead_EX=0 -> exactly one cycle with PCWrite=0, NotStall=0, Bubble_EX=1; StallCycles=1. Repeat with Rt_EX=0 -> no stall.
- Rt_EX=9 equals ReadReg2_ID=9: with UsesRt_ID=0 -> no stall; with UsesRt_ID=1 -> one stall cycle.
- BranchTaken_EX=1 together with a load-use hit and MulStart_ID=1 -> Flush=1, Bubble_EX=1, NotStall=1, no MUL_WAIT entry; FlushCount=1. Jump_ID=1 alone -> Flush=1, Bubble_EX=0.
- MulStart_ID=1 with MUL_CYCLES=4 -> 1 normal cycle, then 3 cycles of MulBusy=1, Hold_EX=1, NotStall=0 (Jump_ID=1 ignored during them), then RUN; StallCycles=3. With MUL_CYCLES=1 -> no stall.
- Hold the load-use condition for 70000 cycles -> StallCycles saturates at 65535 and does not wrap.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for the 5-stage MIPS pipeline.
// Drives the PC, IF/ID and ID/EX pipeline controls for three cases:
// load-use stalls, branch/jump flushes and multi-cycle multiply occupancy
// of EX. It also keeps saturating stall and flush event counters.
module hazard_ctrl_unit #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead_EX,
   input  logic [4:0]  Rt_EX,
   input  logic [4:0]  ReadReg1_ID,
   input  logic [4:0]  ReadReg2_ID,
   input  logic        UsesRt_ID,
   input  logic        Jump_ID,
   input  logic        BranchTaken_EX,
   input  logic        MulStart_ID,
   output logic        PCWrite,
   output logic        NotStall,
   output logic        Flush,
   output logic        Bubble_EX,
   output logic        Hold_EX,
   output logic        MulBusy,
   output logic [15:0] StallCycles,
   output logic [15:0] FlushCount
);

   localparam logic RUN      = 1'b0;
   localparam logic MUL_WAIT = 1'b1;

   // Count loaded on MUL_WAIT entry: the cycle in which the multiply
   // enters EX already counts as one of its MUL_CYCLES.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   logic        state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;
   logic        loadUse;

   // A load in EX whose destination is a live source of the ID instruction.
   // Register 0 is never a real dependency.
   assign loadUse = MemRead_EX && (Rt_EX != 5'd0) &&
                    ((Rt_EX == ReadReg1_ID) ||
                     (UsesRt_ID && (Rt_EX == ReadReg2_ID)));

   // Mealy control outputs and next-state selection, in hazard priority order.
   always_comb begin
      PCWrite   = 1'b1;
      NotStall  = 1'b1;
      Flush     = 1'b0;
      Bubble_EX = 1'b0;
      Hold_EX   = 1'b0;
      MulBusy   = 1'b0;
      state_d   = state_q;
      count_d   = count_q;
      if (!Reset) begin
         case (state_q)
            RUN: begin
               if (BranchTaken_EX) begin
                  Flush     = 1'b1;
                  Bubble_EX = 1'b1;
               end else if (Jump_ID) begin
                  Flush     = 1'b1;
               end else if (loadUse) begin
                  PCWrite   = 1'b0;
                  NotStall  = 1'b0;
                  Bubble_EX = 1'b1;
               end else if (MulStart_ID && (MUL_CYCLES > 1)) begin
                  state_d   = MUL_WAIT;
                  count_d   = MUL_LOAD;
               end
            end
            MUL_WAIT: begin
               PCWrite  = 1'b0;
               NotStall = 1'b0;
               Hold_EX  = 1'b1;
               MulBusy  = 1'b1;
               count_d  = count_q - 4'd1;
               if (count_q == 4'd1) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               count_d = 4'd0;
            end
         endcase
      end
   end

   // Saturating event counters, fed by this cycle's control outputs.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!NotStall && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
      if (Flush && (flush_q != 16'hFFFF)) begin
         flush_d = flush_q + 16'd1;
      end
   end

   // State and counter registers; reset aborts any multiply wait at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= RUN;
         count_q <= 4'd0;
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign StallCycles = stall_q;
   assign FlushCount  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: table-driven single-cycle
// vectors, hand-written multiply/reset/saturation sequences, and an
// expected-output queue popped when the outputs are sampled.
module tb_hazard_ctrl_unit;

   typedef struct {
      string      name;
      logic       memRead;
      logic [4:0] rtEx;
      logic [4:0] rr1;
      logic [4:0] rr2;
      logic       usesRt;
      logic       jump;
      logic       branch;
      logic       mulStart;
      logic [5:0] expOut;   // {PCWrite,NotStall,Flush,Bubble_EX,Hold_EX,MulBusy}
   } vec_t;

   localparam logic [5:0] OUT_NORMAL = 6'b110000;
   localparam logic [5:0] OUT_STALL  = 6'b000100;
   localparam logic [5:0] OUT_BRANCH = 6'b111100;
   localparam logic [5:0] OUT_JUMP   = 6'b111000;
   localparam logic [5:0] OUT_BUSY   = 6'b000011;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MemRead_EX, UsesRt_ID, Jump_ID, BranchTaken_EX, MulStart_ID;
   logic [4:0]  Rt_EX, ReadReg1_ID, ReadReg2_ID;
   logic        PCWrite, NotStall, Flush, Bubble_EX, Hold_EX, MulBusy;
   logic [15:0] StallCycles, FlushCount;
   logic        PCWrite1, NotStall1, Flush1, Bubble1, Hold1, MulBusy1;
   logic [15:0] StallCycles1, FlushCount1;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [15:0] expStall = 16'd0;
   logic [15:0] expFlush = 16'd0;
   logic        pendStall = 1'b0;
   logic        pendFlush = 1'b0;
   logic [5:0]  expQ[$];
   vec_t        table_v[$];

   always #5 Clk = ~Clk;

   hazard_ctrl_unit #(.MUL_CYCLES(4)) dut (
      .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
      .ReadReg1_ID(ReadReg1_ID), .ReadReg2_ID(ReadReg2_ID), .UsesRt_ID(UsesRt_ID),
      .Jump_ID(Jump_ID), .BranchTaken_EX(BranchTaken_EX), .MulStart_ID(MulStart_ID),
      .PCWrite(PCWrite), .NotStall(NotStall), .Flush(Flush), .Bubble_EX(Bubble_EX),
      .Hold_EX(Hold_EX), .MulBusy(MulBusy), .StallCycles(StallCycles),
      .FlushCount(FlushCount)
   );

   hazard_ctrl_unit #(.MUL_CYCLES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
      .ReadReg1_ID(ReadReg1_ID), .ReadReg2_ID(ReadReg2_ID), .UsesRt_ID(UsesRt_ID),
      .Jump_ID(Jump_ID), .BranchTaken_EX(BranchTaken_EX), .MulStart_ID(MulStart_ID),
      .PCWrite(PCWrite1), .NotStall(NotStall1), .Flush(Flush1), .Bubble_EX(Bubble1),
      .Hold_EX(Hold1), .MulBusy(MulBusy1), .StallCycles(StallCycles1),
      .FlushCount(FlushCount1)
   );

   function automatic vec_t mk(input string n, input logic mr, input logic [4:0] rt,
                               input logic [4:0] r1, input logic [4:0] r2, input logic ur,
                               input logic j, input logic b, input logic m,
                               input logic [5:0] e);
      vec_t v;
      v.name = n; v.memRead = mr; v.rtEx = rt; v.rr1 = r1; v.rr2 = r2;
      v.usesRt = ur; v.jump = j; v.branch = b; v.mulStart = m; v.expOut = e;
      return v;
   endfunction

   function automatic logic [15:0] satInc(input logic [15:0] v, input logic inc);
      return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
   task automatic applyStimulus(input vec_t v);
      @(posedge Clk);
      expStall  = satInc(expStall, pendStall);
      expFlush  = satInc(expFlush, pendFlush);
      pendStall = 1'b0;
      pendFlush = 1'b0;
      #1;
      MemRead_EX = v.memRead; Rt_EX = v.rtEx; ReadReg1_ID = v.rr1;
      ReadReg2_ID = v.rr2; UsesRt_ID = v.usesRt; Jump_ID = v.jump;
      BranchTaken_EX = v.branch; MulStart_ID = v.mulStart;
      expQ.push_back(v.expOut);
   endtask

   // Sample on the falling edge and compare against the oldest queued expectation.
   task automatic checkOutput(input string name);
      logic [5:0] e;
      @(negedge Clk);
      if (expQ.size() == 0) begin
         check({name, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         check(name, {26'd0, PCWrite, NotStall, Flush, Bubble_EX, Hold_EX, MulBusy},
               {26'd0, e});
         pendStall = ~e[4];
         pendFlush = e[3];
      end
   endtask

   task automatic checkCounters(input string name);
      check({name, "_stall"}, {16'd0, StallCycles}, {16'd0, expStall});
      check({name, "_flush"}, {16'd0, FlushCount}, {16'd0, expFlush});
   endtask

   task automatic checkDut1(input string name, input logic [5:0] e);
      check(name, {26'd0, PCWrite1, NotStall1, Flush1, Bubble1, Hold1, MulBusy1},
            {26'd0, e});
   endtask

   task automatic clearModel();
      expStall = 16'd0; expFlush = 16'd0; pendStall = 1'b0; pendFlush = 1'b0;
      expQ.delete();
   endtask

   initial begin
      Reset = 1'b1;
      MemRead_EX = 0; Rt_EX = 0; ReadReg1_ID = 0; ReadReg2_ID = 0;
      UsesRt_ID = 0; Jump_ID = 0; BranchTaken_EX = 0; MulStart_ID = 0;
      #1;
      check("reset_outputs", {26'd0, PCWrite, NotStall, Flush, Bubble_EX, Hold_EX, MulBusy},
            {26'd0, OUT_NORMAL});
      checkCounters("reset");
      @(negedge Clk);
      Reset = 1'b0;

      // Single-cycle vectors from RUN; each row leaves the unit back in RUN.
      table_v.push_back(mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, OUT_NORMAL));
      table_v.push_back(mk("loaduse_rs",    1, 8, 8, 0, 0, 0, 0, 0, OUT_STALL));
      table_v.push_back(mk("after_load",    0, 8, 8, 0, 0, 0, 0, 0, OUT_NORMAL));
      table_v.push_back(mk("rt_zero",       1, 0, 0, 0, 0, 0, 0, 0, OUT_NORMAL));
      table_v.push_back(mk("rt_unused",     1, 9, 1, 9, 0, 0, 0, 0, OUT_NORMAL));
      table_v.push_back(mk("rt_used",       1, 9, 1, 9, 1, 0, 0, 0, OUT_STALL));
      table_v.push_back(mk("branch_all",    1, 8, 8, 0, 0, 0, 1, 1, OUT_BRANCH));
      table_v.push_back(mk("jump_alone",    0, 0, 0, 0, 0, 1, 0, 0, OUT_JUMP));
      table_v.push_back(mk("jump_loaduse",  1, 5, 5, 0, 0, 1, 0, 0, OUT_JUMP));
      table_v.push_back(mk("loaduse_mul",   1, 7, 0, 7, 1, 0, 0, 1, OUT_STALL));
      table_v.push_back(mk("no_load",       0, 7, 7, 7, 1, 0, 0, 0, OUT_NORMAL));
      table_v.push_back(mk("load_mismatch", 1, 8, 3, 4, 1, 0, 0, 0, OUT_NORMAL));
      foreach (table_v[i]) begin
         applyStimulus(table_v[i]);
         checkOutput(table_v[i].name);
      end
      checkCounters("table");

      // Multiply occupancy: one normal cycle, three held cycles ignoring jumps, then RUN.
      applyStimulus(mk("mul_start", 0, 0, 0, 0, 0, 0, 0, 1, OUT_NORMAL));
      checkOutput("mul_start");
      checkDut1("mul1_start", OUT_NORMAL);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mk("mul_wait", 0, 0, 0, 0, 0, 1, 0, 0, OUT_BUSY));
         checkOutput($sformatf("mul_wait%0d", i));
         if (i == 0) checkDut1("mul1_no_wait", OUT_JUMP);
      end
      applyStimulus(mk("mul_done", 0, 0, 0, 0, 0, 0, 0, 0, OUT_NORMAL));
      checkOutput("mul_done");
      checkCounters("mul");

      // Reset while the multiply wait has Count=2 left.
      applyStimulus(mk("mul_start2", 0, 0, 0, 0, 0, 0, 0, 1, OUT_NORMAL));
      checkOutput("mul_start2");
      applyStimulus(mk("mul_w3", 0, 0, 0, 0, 0, 0, 0, 0, OUT_BUSY));
      checkOutput("mul_w3");
      applyStimulus(mk("mul_w2", 0, 0, 0, 0, 0, 0, 0, 0, OUT_BUSY));
      checkOutput("mul_w2");
      #1;
      Reset = 1'b1;
      #1;
      clearModel();
      check("reset_midwait", {26'd0, PCWrite, NotStall, Flush, Bubble_EX, Hold_EX, MulBusy},
            {26'd0, OUT_NORMAL});
      checkCounters("reset_midwait");
      @(negedge Clk);
      Reset = 1'b0;
      applyStimulus(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, OUT_NORMAL));
      checkOutput("post_reset");
      checkCounters("post_reset");

      // Hold a load-use hazard long enough to saturate the stall counter.
      applyStimulus(mk("sat_first", 1, 8, 8, 0, 0, 0, 0, 0, OUT_STALL));
      checkOutput("sat_first");
      repeat (70000) @(posedge Clk);
      for (int i = 0; i < 70000; i++) expStall = satInc(expStall, 1'b1);
      expStall = satInc(expStall, pendStall);
      pendStall = 1'b0;
      @(negedge Clk);
      checkCounters("saturate");
      check("sat_value", {16'd0, StallCycles}, 32'h0000FFFF);
      check("sat_still_stall", {31'd0, NotStall}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
